vga_char_motion_ctrl: RTL

//  Per-frame scheduler for the character-bitmap overlay origin. Produces char_b_h/char_b_v and char_color for
//  the pixel generator, moving a CHAR_W x CHAR_H glyph box around the active area.
//  The box bounces off the screen edges. Updates only at frame start, so no frame ever tears.

---
 rtl/vga_char_motion_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/vga_char_motion_ctrl.sv
// vga_char_motion_ctrl: per-frame scheduler for the character overlay origin.
// Moves a CHAR_W x CHAR_H glyph box around the active area and bounces it off
// the screen edges. The origin only changes on a vsync rising edge, so a frame
// never tears.
// Optional feature: define CHAR_COLOR_CYCLE_EN to step the glyph colour
// through a four-entry palette on every bounce.
module vga_char_motion_ctrl #(
  parameter logic [9:0]  H_ACT     = 10'd640,
  parameter logic [9:0]  V_ACT     = 10'd480,
  parameter logic [9:0]  CHAR_W    = 10'd256,
  parameter logic [9:0]  CHAR_H    = 10'd128,
  parameter logic [9:0]  INIT_H    = 10'd205,
  parameter logic [9:0]  INIT_V    = 10'd216,
  parameter logic [9:0]  STEP      = 10'd2,
  parameter logic [7:0]  FRAME_DIV = 8'd1,
  parameter logic [15:0] COLOR0    = 16'hFFE0
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        vga_vs,
  input  logic        en,
  input  logic        pause,
  output logic [9:0]  char_b_h,
  output logic [9:0]  char_b_v,
  output logic [15:0] char_color,
  output logic        moving,
  output logic        bounce,
  output logic        corner
);

  localparam logic [9:0] X_MAX = H_ACT - CHAR_W;
  localparam logic [9:0] Y_MAX = V_ACT - CHAR_H;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]  r_state;
  logic        r_vs_d;
  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic        r_dx_neg;
  logic        r_dy_neg;
  logic [7:0]  r_frame_cnt;
  logic        r_bounce;
  logic        r_corner;

  logic        w_tick;
  logic        w_frame_wrap;
  logic        w_move;
  logic [11:0] w_x_res;
  logic [11:0] w_y_res;

  // One axis of a move event: returns {bounced, new_dir_neg, new_pos}.
  // The forward sum is widened to 11 bits so it can never wrap past the limit.
  function automatic logic [11:0] f_step(input logic [9:0] pos,
                                         input logic       dir_neg,
                                         input logic [9:0] lim);
    logic [10:0] sum;
    logic [9:0]  np;
    logic        nd;
    logic        bb;
    sum = {1'b0, pos} + {1'b0, STEP};
    np  = pos;
    nd  = dir_neg;
    bb  = 1'b0;
    if (!dir_neg) begin
      if (sum >= {1'b0, lim}) begin
        np = lim;
        nd = 1'b1;
        bb = 1'b1;
      end else begin
        np = sum[9:0];
      end
    end else if (pos <= STEP) begin
      np = '0;
      nd = 1'b0;
      bb = 1'b1;
    end else begin
      np = pos - STEP;
    end
    return {bb, nd, np};
  endfunction

  assign w_tick       = vga_vs & ~r_vs_d;
  assign w_frame_wrap = (r_frame_cnt == (FRAME_DIV - 8'd1));
  assign w_move       = (r_state == S_RUN) & en & ~pause & w_tick & w_frame_wrap;
  assign w_x_res      = f_step(r_h, r_dx_neg, X_MAX);
  assign w_y_res      = f_step(r_v, r_dy_neg, Y_MAX);

  // Delayed vsync for rising-edge detection.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) r_vs_d <= 1'b0;
    else         r_vs_d <= vga_vs;
  end

  // Mode FSM plus origin, direction, frame divider and event pulses.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_h         <= INIT_H;
      r_v         <= INIT_V;
      r_dx_neg    <= 1'b0;
      r_dy_neg    <= 1'b0;
      r_frame_cnt <= '0;
      r_bounce    <= 1'b0;
      r_corner    <= 1'b0;
    end else begin
      r_bounce <= 1'b0;
      r_corner <= 1'b0;
      if (!en || (r_state == S_IDLE)) begin
        // Disable has priority in every state; IDLE pins the box at home.
        r_h         <= INIT_H;
        r_v         <= INIT_V;
        r_dx_neg    <= 1'b0;
        r_dy_neg    <= 1'b0;
        r_frame_cnt <= '0;
        r_state     <= en ? S_RUN : S_IDLE;
      end else begin
        case (r_state)
          S_RUN: begin
            if (pause) begin
              r_state <= S_PAUSE;
            end else if (w_tick) begin
              if (w_frame_wrap) begin
                r_frame_cnt <= '0;
                r_h         <= w_x_res[9:0];
                r_dx_neg    <= w_x_res[10];
                r_v         <= w_y_res[9:0];
                r_dy_neg    <= w_y_res[10];
                r_bounce    <= w_x_res[11] | w_y_res[11];
                r_corner    <= w_x_res[11] & w_y_res[11];
              end else begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
              end
            end
          end
          S_PAUSE: begin
            if (!pause) r_state <= S_RUN;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign char_b_h = r_h;
  assign char_b_v = r_v;
  assign moving   = (r_state == S_RUN);
  assign bounce   = r_bounce;
  assign corner   = r_corner;

`ifdef CHAR_COLOR_CYCLE_EN
  logic [1:0] r_col_idx;

  // Palette index advances once per bouncing move event (a corner is one step).
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst)                          r_col_idx <= '0;
    else if (!en || (r_state == S_IDLE))  r_col_idx <= '0;
    else if (w_move && (w_x_res[11] || w_y_res[11]))
                                          r_col_idx <= r_col_idx + 2'd1;
  end

  // Palette lookup.
  always_comb begin
    char_color = COLOR0;
    case (r_col_idx)
      2'd1:    char_color = 16'hF800;
      2'd2:    char_color = 16'h07E0;
      2'd3:    char_color = 16'h001F;
      default: char_color = COLOR0;
    endcase
  end
`else
  assign char_color = COLOR0;
`endif

endmodule
